// File: rtl/bcd_upcount_0to39.sv
// bcd_upcount_0to39
// Two-digit BCD up-counter with a small run/pause/done controller.
// The count goes from 00 up to a parameterised top value (TENS_MAX, UNITS_TOP)
// on accepted ticks. The units digit carries into the tens digit on 9 -> 0.
// The outputs drive the display BCD bus and the sequencing logic that waits
// for end-of-count.
//
// Optional feature macro: BCD_UP_WRAP_EN
//   undefined : a tick at top parks the counter in DONE (K_end is a level)
//   defined   : a tick at top wraps to 00 and stays in RUN (K_end is a pulse)
//
// Ports:
//   clock     in   rising-edge system clock
//   reset     in   asynchronous active-high reset, clears all state
//   tick      in   count-enable strobe, counts only in RUN
//   start     in   IDLE->RUN or PAUSE->RUN
//   pause     in   RUN->PAUSE
//   clear     in   synchronous return to IDLE with count 00
//   bcd_units out  units digit 0..9
//   bcd_tens  out  tens digit 0..TENS_MAX
//   K_carry   out  one-cycle pulse after units rolls 9->0
//   K_end     out  top value reached
//   running   out  high while in RUN
module bcd_upcount_0to39 #(
  parameter int TENS_MAX  = 3,
  parameter int UNITS_TOP = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] bcd_units,
  output logic [3:0] bcd_tens,
  output logic       K_carry,
  output logic       K_end,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] TENS_TOP = 4'(TENS_MAX);
  localparam logic [3:0] UNIT_TOP = 4'(UNITS_TOP);
  localparam logic       TOP_ROLLS_UNITS = (UNITS_TOP == 9);

  state_t state;
  logic   at_top;

  // The count is at the configured top value.
  assign at_top = (bcd_units == UNIT_TOP) && (bcd_tens == TENS_TOP);

  // Controller and digit chain in one register block. Every output is a
  // register, so running and K_end are written together with the state they
  // mirror. The input priority is clear, then pause, then start, then tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bcd_units <= 4'd0;
      bcd_tens  <= 4'd0;
      K_carry   <= 1'b0;
      K_end     <= 1'b0;
      running   <= 1'b0;
    end else begin
      K_carry <= 1'b0;
`ifdef BCD_UP_WRAP_EN
      K_end   <= 1'b0;
`endif
      if (clear) begin
        state     <= IDLE;
        bcd_units <= 4'd0;
        bcd_tens  <= 4'd0;
        K_end     <= 1'b0;
        running   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A tick arriving with start is deliberately not counted.
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (tick) begin
              if (at_top) begin
`ifdef BCD_UP_WRAP_EN
                bcd_units <= 4'd0;
                bcd_tens  <= 4'd0;
                K_end     <= 1'b1;
                K_carry   <= TOP_ROLLS_UNITS;
`else
                state     <= DONE;
                K_end     <= 1'b1;
                running   <= 1'b0;
`endif
              end else if (bcd_units == 4'd9) begin
                // Below top, units at 9 always implies tens < TENS_MAX.
                bcd_units <= 4'd0;
                bcd_tens  <= bcd_tens + 4'd1;
                K_carry   <= 1'b1;
              end else begin
                bcd_units <= bcd_units + 4'd1;
              end
            end
          end
          PAUSE: begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            // Parked at top until clear or reset.
            state <= DONE;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_upcount_0to39.sv
// tb_bcd_upcount_0to39
// Scoreboard bench for bcd_upcount_0to39. The stimulus process drives one
// input vector per clock and pushes the response predicted by a count-level
// reference model. A separate monitor pops each prediction after the clock
// edge and compares it with the DUT outputs. Asynchronous reset is checked
// directly between edges.
module tb_bcd_upcount_0to39;

`ifdef BCD_UP_WRAP_EN
  localparam int TM = 1;
  localparam int UT = 5;
`else
  localparam int TM = 3;
  localparam int UT = 9;
`endif
  localparam int TOP = TM * 10 + UT;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    logic [3:0] u;
    logic [3:0] t;
    logic       c;
    logic       e;
    logic       r;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick, start, pause, clear;
  logic [3:0] bcd_units, bcd_tens;
  logic       K_carry, K_end, running;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  int    m_count;
  int    m_mode;

  bcd_upcount_0to39 #(.TENS_MAX(TM), .UNITS_TOP(UT)) dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start),
    .pause(pause), .clear(clear), .bcd_units(bcd_units),
    .bcd_tens(bcd_tens), .K_carry(K_carry), .K_end(K_end),
    .running(running)
  );

  always #5 clock = ~clock;

  // Compare DUT outputs with one expected response.
  task automatic checkOutput(input exp_t e, input string name);
    checks++;
    if (bcd_units !== e.u || bcd_tens !== e.t || K_carry !== e.c ||
        K_end !== e.e || running !== e.r) begin
      errors++;
      $display("[TB] FAIL %s: got tens=%0d units=%0d carry=%b end=%b run=%b, expected tens=%0d units=%0d carry=%b end=%b run=%b",
               name, bcd_tens, bcd_units, K_carry, K_end, running,
               e.t, e.u, e.c, e.e, e.r);
    end
  endtask

  // Reference model: the count is a plain integer 0..TOP, digits are derived
  // by division, and a carry is any accepted step that lands on a multiple
  // of ten.
  task automatic modelStep(input logic clr, pau, sta, tck, output exp_t e);
    logic c;
    logic en;
    c  = 1'b0;
    en = 1'b0;
    if (clr) begin
      m_mode  = M_IDLE;
      m_count = 0;
    end else begin
      case (m_mode)
        M_IDLE:  if (sta) m_mode = M_RUN;
        M_RUN: begin
          if (pau) m_mode = M_PAUSE;
          else if (tck) begin
            if (m_count == TOP) begin
`ifdef BCD_UP_WRAP_EN
              m_count = 0;
              en      = 1'b1;
              c       = (UT == 9);
`else
              m_mode  = M_DONE;
`endif
            end else begin
              m_count = m_count + 1;
              c       = (m_count % 10 == 0);
            end
          end
        end
        M_PAUSE: if (sta) m_mode = M_RUN;
        default: ;
      endcase
    end
    e.u = 4'(m_count % 10);
    e.t = 4'(m_count / 10);
    e.c = c;
`ifdef BCD_UP_WRAP_EN
    e.e = en;
`else
    e.e = (m_mode == M_DONE);
`endif
    e.r = (m_mode == M_RUN);
  endtask

  // Drive one cycle of inputs and queue the predicted response.
  task automatic applyStimulus(input logic clr, pau, sta, tck, input string name);
    exp_t e;
    @(negedge clock);
    clear = clr;
    pause = pau;
    start = sta;
    tick  = tck;
    modelStep(clr, pau, sta, tck, e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Assert reset between edges and check that outputs clear before any edge.
  task automatic midReset();
    exp_t z;
    z = '{u: 4'd0, t: 4'd0, c: 1'b0, e: 1'b0, r: 1'b0};
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "pre_reset_idle");
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput(z, "async_reset");
    m_count = 0;
    m_mode  = M_IDLE;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: one expected response is consumed after every clock edge that
  // has a prediction pending.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), name_q.pop_front());
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_t z;
    logic r_clr, r_pau, r_sta, r_tck;
    z = '{u: 4'd0, t: 4'd0, c: 1'b0, e: 1'b0, r: 1'b0};
    reset = 1'b1;
    clear = 1'b0;
    pause = 1'b0;
    start = 1'b0;
    tick  = 1'b0;
    m_count = 0;
    m_mode  = M_IDLE;
    #1;
    checkOutput(z, "reset_state");
    #20;
    @(negedge clock);
    reset = 1'b0;

    // IDLE gating: start with tick starts without counting.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "idle_start_tick");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "first_tick");
    repeat (26) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "count_to_27");
    midReset();

    // Full count, top tick, and behaviour after top.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "start_full");
    repeat (TOP) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "full_count");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "tick_at_top");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "after_top_tick");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "after_top_pause");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "after_top_start");

    // Clear behaviour.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "clear_from_top");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, "clear_beats_start");

    // Priority of pause over tick and resume from PAUSE.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "start_prio");
    repeat (14) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "count_to_14");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "pause_beats_tick");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "pause_ignores_tick");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "resume_drops_tick");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "resume_tick");

    // Randomised traffic with occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) midReset();
      r_clr = ($urandom_range(0, 47) == 0);
      r_pau = ($urandom_range(0, 9) == 0);
      r_sta = ($urandom_range(0, 3) == 0);
      r_tck = ($urandom_range(0, 1) == 0);
      applyStimulus(r_clr, r_pau, r_sta, r_tck, "random");
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "final_idle");

    // Let the monitor drain the scoreboard within a bounded number of edges.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d responses still pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
